// File: rtl/reduce_nway_pipe.sv
// N-input AND/OR/XOR reduction with optional inversion, built as a registered binary tree.
// One pipeline stage per tree level, valid/ready flow control and a consumed-result counter.
module reduce_nway_pipe #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in_data,
    input  logic [1:0]       in_op,
    input  logic             in_inv,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] result_count
);

    localparam int LEVELS = $clog2(N);
    localparam int P      = 1 << LEVELS;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef struct packed {
        op_e  op;
        logic inv;
    } meta_t;

    function automatic logic red2(input op_e op, input logic a, input logic b);
        case (op)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Whole pipe shifts together or holds together; bubbles are never squeezed out.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // meta_w[k] is the op/inv travelling alongside level-k data (level 0 = the input port).
    meta_t meta_w [LEVELS];
    assign meta_w[0] = '{op: op_e'(in_op), inv: in_inv};

    if (LEVELS > 1) begin : g_meta
        meta_t meta_q [1:LEVELS-1];

        always_ff @(posedge clk or posedge reset) begin
            // NOTE: this is a handful of flops, not a RAM, so every element is cleared on reset.
            if (reset) begin
                for (int k = 1; k < LEVELS; k++) meta_q[k] <= '0;
            end else if (adv) begin
                for (int k = 1; k < LEVELS; k++) meta_q[k] <= meta_w[k-1];
            end
        end

        for (genvar k = 1; k < LEVELS; k++) begin : g_tap
            assign meta_w[k] = meta_q[k];
        end
    end

    logic [LEVELS:1] valid_q;
    logic [LEVELS:0] valid_w;
    assign valid_w = {valid_q, in_valid};

    // Leaves sit at heap indices P..2P-1; unused leaves carry the identity of the op.
    logic [2*P-1:P] leaf_w;
    logic           pad;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        pad    = ~((meta_w[0].op == OP_OR) || (meta_w[0].op == OP_XOR));
        leaf_w = {P{pad}};
        for (int i = 0; i < N; i++) leaf_w[P+i] = in_data[i];
    end

    // Internal heap nodes 1..P-1; node i has children 2i and 2i+1, node 1 is the root.
    logic [P-1:1] tree_q, tree_d;

    always_comb begin
        tree_d = tree_q;
        for (int k = 1; k <= LEVELS; k++) begin
            for (int i = 1 << (LEVELS - k); i < (2 << (LEVELS - k)); i++) begin
                if (k == 1) tree_d[i] = red2(meta_w[0].op, leaf_w[2*i], leaf_w[2*i+1]);
                else        tree_d[i] = red2(meta_w[k-1].op, tree_q[2*i], tree_q[2*i+1]);
            end
        end
        tree_d[1] = tree_d[1] ^ meta_w[LEVELS-1].inv;
    end

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample together.
        if (reset) begin
            valid_q <= '0;
            tree_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (adv) begin
                valid_q <= valid_w[LEVELS-1:0];
                tree_q  <= tree_d;
            end
        end
    end

    assign out_data     = tree_q[1];
    assign out_valid    = valid_q[LEVELS];
    assign result_count = count_q;

endmodule

// File: tb/tb_reduce_nway_pipe.sv
// Directed bench for reduce_nway_pipe: N=8, N=5, N=2 and a 2-bit counter variant
// share one clock and reset; expected values are hand-computed per vector.
module tb_reduce_nway_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] op;
    logic       inv;
    logic       out_ready;

    logic [7:0]  d8_data;
    logic        d8_valid, d8_ir, d8_od, d8_ov;
    logic [15:0] d8_cnt;

    logic [4:0]  d5_data;
    logic        d5_valid, d5_ir, d5_od, d5_ov;
    logic [15:0] d5_cnt;

    logic [1:0]  d2_data;
    logic        d2_valid, d2_ir, d2_od, d2_ov;
    logic [15:0] d2_cnt;

    logic [7:0]  dc_data;
    logic        dc_valid, dc_ir, dc_od, dc_ov;
    logic [1:0]  dc_cnt;

    reduce_nway_pipe #(.N(8), .CNT_W(16)) u_d8 (
        .clk(clk), .reset(reset), .in_data(d8_data), .in_op(op), .in_inv(inv),
        .in_valid(d8_valid), .in_ready(d8_ir), .out_data(d8_od), .out_valid(d8_ov),
        .out_ready(out_ready), .result_count(d8_cnt)
    );

    reduce_nway_pipe #(.N(5), .CNT_W(16)) u_d5 (
        .clk(clk), .reset(reset), .in_data(d5_data), .in_op(op), .in_inv(inv),
        .in_valid(d5_valid), .in_ready(d5_ir), .out_data(d5_od), .out_valid(d5_ov),
        .out_ready(out_ready), .result_count(d5_cnt)
    );

    reduce_nway_pipe #(.N(2), .CNT_W(16)) u_d2 (
        .clk(clk), .reset(reset), .in_data(d2_data), .in_op(op), .in_inv(inv),
        .in_valid(d2_valid), .in_ready(d2_ir), .out_data(d2_od), .out_valid(d2_ov),
        .out_ready(out_ready), .result_count(d2_cnt)
    );

    reduce_nway_pipe #(.N(8), .CNT_W(2)) u_dc (
        .clk(clk), .reset(reset), .in_data(dc_data), .in_op(op), .in_inv(inv),
        .in_valid(dc_valid), .in_ready(dc_ir), .out_data(dc_od), .out_valid(dc_ov),
        .out_ready(out_ready), .result_count(dc_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Back-to-back mixed-op beats for N=8.
    logic [7:0] t3_d   [5] = '{8'h00, 8'h01, 8'h07, 8'h03, 8'hFF};
    logic [1:0] t3_op  [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    logic       t3_inv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       t3_exp [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // N=5 beats exercising both padding values and the reserved op.
    logic [4:0] t4_d   [6] = '{5'h1F, 5'h01, 5'h00, 5'h1F, 5'h0F, 5'h1E};
    logic [1:0] t4_op  [6] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    logic       t4_inv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       t4_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // N=2 beats: single-stage latency.
    logic [1:0] t2_d   [4] = '{2'b11, 2'b10, 2'b10, 2'b00};
    logic [1:0] t2_op  [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
    logic       t2_inv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       t2_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        op        = 2'b00;
        inv       = 1'b0;
        out_ready = 1'b1;
        d8_data = '0; d8_valid = 1'b0;
        d5_data = '0; d5_valid = 1'b0;
        d2_data = '0; d2_valid = 1'b0;
        dc_data = '0; dc_valid = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk1("rst_ov", d8_ov, 1'b0);
        chk1("rst_od", d8_od, 1'b0);
        chkn("rst_cnt", 32'(d8_cnt), 32'd0);
        chk1("rst_in_ready", d8_ir, 1'b1);

        // Single beats, 3-cycle latency on N=8.
        d8_data = 8'hFF; op = 2'b00; inv = 1'b0; d8_valid = 1'b1;
        step();
        d8_valid = 1'b0;
        step();
        chk1("lat_early_ov", d8_ov, 1'b0);
        step();
        chk1("lat_ff_ov", d8_ov, 1'b1);
        chk1("lat_ff_od", d8_od, 1'b1);
        d8_data = 8'hFE; d8_valid = 1'b1;
        step();
        d8_valid = 1'b0;
        step();
        step();
        chk1("lat_fe_ov", d8_ov, 1'b1);
        chk1("lat_fe_od", d8_od, 1'b0);
        step();
        chk1("lat_done_ov", d8_ov, 1'b0);
        chkn("lat_cnt", 32'(d8_cnt), 32'd2);

        // Async reset between edges while a result is held at the output.
        out_ready = 1'b0;
        d8_data = 8'hFF; op = 2'b00; d8_valid = 1'b1;
        step();
        d8_valid = 1'b0;
        step();
        step();
        chk1("hold_pre_rst_ov", d8_ov, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk1("async_rst_ov", d8_ov, 1'b0);
        chk1("async_rst_od", d8_od, 1'b0);
        chkn("async_rst_cnt", 32'(d8_cnt), 32'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        chk1("post_rst_in_ready", d8_ir, 1'b1);

        // Backpressure: four beats, five stalled cycles, then drain in order.
        d8_data = 8'hA5; op = 2'b10; inv = 1'b0; d8_valid = 1'b1;
        step();
        d8_data = 8'h80; op = 2'b01;
        step();
        d8_data = 8'h7F; op = 2'b00;
        step();
        chk1("bp_first_ov", d8_ov, 1'b1);
        chk1("bp_first_od", d8_od, 1'b0);
        out_ready = 1'b0;
        d8_data = 8'h01; op = 2'b10;
        for (int s = 0; s < 5; s++) begin
            step();
            chk1($sformatf("bp_stall%0d_ov", s), d8_ov, 1'b1);
            chk1($sformatf("bp_stall%0d_od", s), d8_od, 1'b0);
            chk1($sformatf("bp_stall%0d_in_ready", s), d8_ir, 1'b0);
        end
        out_ready = 1'b1;
        step();
        d8_valid = 1'b0;
        chk1("bp_r1_od", d8_od, 1'b1);
        chk1("bp_r1_ov", d8_ov, 1'b1);
        step();
        chk1("bp_r2_od", d8_od, 1'b0);
        chk1("bp_r2_ov", d8_ov, 1'b1);
        step();
        chk1("bp_r3_od", d8_od, 1'b1);
        chk1("bp_r3_ov", d8_ov, 1'b1);
        step();
        chk1("bp_drained_ov", d8_ov, 1'b0);
        chkn("bp_cnt", 32'(d8_cnt), 32'd4);

        // Back-to-back beats with mixed ops, one result per cycle.
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                d8_data = t3_d[i]; op = t3_op[i]; inv = t3_inv[i]; d8_valid = 1'b1;
            end else begin
                d8_valid = 1'b0;
            end
            step();
            if (i >= 2) begin
                chk1($sformatf("b2b%0d_ov", i - 2), d8_ov, 1'b1);
                chk1($sformatf("b2b%0d_od", i - 2), d8_od, t3_exp[i-2]);
            end
        end
        step();
        chk1("b2b_done_ov", d8_ov, 1'b0);
        chkn("b2b_cnt", 32'(d8_cnt), 32'd9);

        // N=5: padding with the identity of each op.
        chk1("n5_in_ready", d5_ir, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                d5_data = t4_d[i]; op = t4_op[i]; inv = t4_inv[i]; d5_valid = 1'b1;
            end else begin
                d5_valid = 1'b0;
            end
            step();
            if (i >= 2) begin
                chk1($sformatf("n5_%0d_ov", i - 2), d5_ov, 1'b1);
                chk1($sformatf("n5_%0d_od", i - 2), d5_od, t4_exp[i-2]);
            end
        end
        step();
        chk1("n5_done_ov", d5_ov, 1'b0);
        chkn("n5_cnt", 32'(d5_cnt), 32'd6);

        // N=2: one-cycle latency.
        chk1("n2_in_ready", d2_ir, 1'b1);
        for (int i = 0; i < 4; i++) begin
            d2_data = t2_d[i]; op = t2_op[i]; inv = t2_inv[i]; d2_valid = 1'b1;
            step();
            chk1($sformatf("n2_%0d_ov", i), d2_ov, 1'b1);
            chk1($sformatf("n2_%0d_od", i), d2_od, t2_exp[i]);
        end
        d2_valid = 1'b0;
        step();
        chk1("n2_done_ov", d2_ov, 1'b0);
        chkn("n2_cnt", 32'(d2_cnt), 32'd4);

        // CNT_W=2: counter wraps 1,2,3,0,1.
        chk1("cw_in_ready", dc_ir, 1'b1);
        op = 2'b10; inv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                dc_data = 8'(i); dc_valid = 1'b1;
            end else begin
                dc_valid = 1'b0;
            end
            step();
            if (i >= 3) chkn($sformatf("cw_cnt%0d", i - 2), 32'(dc_cnt), 32'((i - 2) % 4));
        end

        // Reset with two results in flight: neither may emerge afterwards.
        dc_data = 8'hFF; op = 2'b00; dc_valid = 1'b1;
        step();
        dc_data = 8'h00; op = 2'b01;
        step();
        dc_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chkn("cw_rst_cnt", 32'(dc_cnt), 32'd0);
        step();
        reset = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk1($sformatf("cw_flush%0d_ov", s), dc_ov, 1'b0);
        end
        dc_data = 8'hFF; op = 2'b00; dc_valid = 1'b1;
        step();
        dc_valid = 1'b0;
        step();
        chk1("cw_post_early_ov", dc_ov, 1'b0);
        step();
        chk1("cw_post_ov", dc_ov, 1'b1);
        chk1("cw_post_od", dc_od, 1'b1);
        step();
        chkn("cw_post_cnt", 32'(dc_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reduce_nway_pipe.md
Name: reduce_nway_pipe

Overview:
Parametrised N-input logic reduction unit (AND/OR/XOR with optional output inversion), built as a registered binary tree with one pipeline stage per tree level. Successor to the fixed 8-input combinational AND tree. Adds selectable operation, arbitrary width, valid/ready flow control with backpressure, and a completed-result counter. Used wherever wide vector reductions feed clocked datapaths.

Parameters:
N, 8, number of input bits reduced (N >= 2; need not be a power of 2)
CNT_W, 16, width of completed-result counter
LEVELS, clog2(N), derived localparam, not overridable; number of tree levels = pipeline depth

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_data  input  N  vector to reduce
in_op  input  2  00=AND, 01=OR, 10=XOR, 11=AND (reserved, treated as AND)
in_inv  input  1  1 = invert final result (NAND/NOR/XNOR)
in_valid  input  1  in_data/in_op/in_inv valid this cycle
in_ready  output  1  unit accepts input this cycle
out_data  output  1  reduction result
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
result_count  output  CNT_W  number of results consumed downstream

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high; all flops clear immediately on reset assertion, independent of clk.
- Reset values: out_data=0, out_valid=0, result_count=0, all stage valid bits=0, all stage data=0. in_ready=1 while reset is low and the pipe is empty.
- Padding: in_data is extended to 2^LEVELS bits with the identity element of in_op (1 for AND, 0 for OR/XOR) at level 0, before the first register.
- Stage k (1..LEVELS) registers the pairwise op of stage k-1's bits, plus a valid bit, op and inv. op/inv travel with their data; different ops may be in flight simultaneously.
- Inversion is applied at the last stage, so out_data = inv ^ reduce(op, in_data).
- Latency: an accepted input appears on out_data/out_valid exactly LEVELS cycles after acceptance if there are no stalls (N=8: 3 cycles; N=5: 3 cycles; N=2: 1 cycle).
- Advance: adv = ~out_valid | out_ready. When adv=1, every stage shifts by one. When adv=0, every stage holds, including bubbles (no bubble collapsing).
- in_ready = adv, a combinational function of out_valid and out_ready. Acceptance = in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 1.
- Throughput: 1 result/cycle when out_ready is held at 1.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Counter: result_count increments by 1 on each cycle with out_valid & out_ready. It wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-operation: all in-flight results are discarded and the counter clears. The first input accepted after reset deassertion follows normal latency.
- in_op=11 behaves identically to 00, including the padding value.

Test Plan:
1. N=8: reset asserted asynchronously between clock edges -> out_valid, out_data and result_count go to 0 before the next edge; in_ready=1 once reset is released.
2. N=8, out_ready=1, single beat in_data=8'hFF, op=AND, inv=0 -> out_valid=1 with out_data=1 exactly 3 cycles later; then 8'hFE -> 0; result_count=2.
3. N=8, out_ready=1, back-to-back beats {8'h00 OR}, {8'h01 OR}, {8'h07 XOR}, {8'h03 XOR inv=1}, {8'hFF AND inv=1} -> outputs 0,1,1,1,0 on consecutive cycles starting at cycle 3.
4. N=5, op=AND, in_data=5'h1F -> 1 after 3 cycles (padding=1). op=XOR, in_data=5'h01 -> 1 (padding=0).
5. Backpressure, N=8: stream 4 beats, hold out_ready=0 for 5 cycles once out_valid=1 -> out_data stable, in_ready=0, no loss or duplication. Release out_ready -> remaining results in order, result_count=4.
6. CNT_W=2: consume 5 results -> result_count sequence 1,2,3,0,1. Reset asserted with 2 results in flight -> no out_valid for them after release.
